multicycle_adder: RTL and testbench
===================================

// Module: multicycle_adder
// PURPOSE
//  Parametrised WIDTH-bit adder/subtractor that ripples carry across CHUNK-bit slices, one slice per clock.
//  Trades latency for a short critical path. Generalises the 4-bit ripple adder to any width, adds subtract mode and a valid/ready handshake on both sides.
//  Sits between register-file operand latches and the ALU result mux in the datapath.
// PARAMETERS
//  WIDTH   16  operand/result width in bits
//  CHUNK   4   bits added per clock; WIDTH % CHUNK must be 0, else elaboration error
//  NCHUNK = WIDTH/CHUNK (derived localparam); slice counter width = max(1,$clog2(NCHUNK))
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (add mode only)
//  sub        in   1      1: A - B; 0: A + B + cin
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      final carry; in sub mode 1 = no borrow
//  ovf        out  1      signed overflow (only with ADDER_OVF_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1 after reset; out_valid, sum, cout, ovf, slice counter, carry reg = 0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready edge:
//    - latch a; latch b_eff = sub ? ~b : b; carry = sub ? 1 : cin (cin ignored when sub=1).
//    - clear sum, slice=0, go RUN.
//   RUN: in_ready=0, out_valid=0. Each edge, slice k:
//    {carry, sum[k*CHUNK +: CHUNK]} = a[k*CHUNK +: CHUNK] + b_eff[k*CHUNK +: CHUNK] + carry.
//    Slice increments. After slice NCHUNK-1: cout=carry_out, go DONE.
//   DONE: out_valid=1; sum/cout/ovf stable. Edge with out_ready=1 -> IDLE, out_valid=0.
//  Latency: out_valid rises exactly NCHUNK edges after the accept edge.
//   Minimum spacing between accepts is NCHUNK+2 cycles.
//  in_valid while in_ready=0 is ignored; operands are not sampled.
//  Operand inputs may change freely after the accept edge.
//  sum holds last result in IDLE until next accept; partial sum during RUN is not valid for consumers.
//  Width: all slice arithmetic is CHUNK+1 bits; no truncation beyond WIDTH; result is modulo 2^WIDTH.
//  NCHUNK=1 (CHUNK==WIDTH): single RUN cycle, latency 1.
//  Reset mid-RUN/DONE: operation discarded, all outputs clear immediately; no partial result is ever flagged valid.
// CONFIGURATION
//  ADDER_OVF_EN defined:
//   - ovf port present; set on the last slice to (a[W-1]==b_eff[W-1]) && (sum[W-1]!=a[W-1]).
//   - ovf held with sum; reset 0.
//  ADDER_OVF_EN undefined: ovf port and its logic omitted; all other behaviour identical.
// TESTING
//  1. W=16,C=4: a=0x1234,b=0x4321,cin=0,sub=0 -> sum=0x5555,cout=0; out_valid 4 cycles after accept.
//  2. a=0xFFFF,b=0x0001,cin=0 -> sum=0x0000,cout=1,ovf=0. Carry crosses all 4 slices.
//  3. sub: a=0x0005,b=0x0007 -> sum=0xFFFE,cout=0,ovf=0. Add a=0x7FFF,b=0x0001 -> sum=0x8000,ovf=1.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout held; in_ready=0; in_valid pulses ignored.
//  5. Reset mid-RUN: rst_n=0 after 2 slices -> outputs 0 immediately. After release, in_ready=1; next op 0x0001+0x0002 -> sum=0x0003.
//  6. Config W=16,C=16 -> latency 1 cycle, 0xABCD+0x1111 -> sum=0xBCDE. Build with and without ADDER_OVF_EN.

Source files
------------

// File: rtl/multicycle_adder.sv
// multicycle_adder
//   WIDTH-bit adder/subtractor that ripples the carry across CHUNK-bit slices,
//   one slice per clock. It uses a short critical path (one CHUNK+1 bit add)
//   at the cost of a latency of NCHUNK = WIDTH/CHUNK cycles. It has a
//   valid/ready handshake on both the operand side and the result side.
//
//   Optional feature macro: ADDER_OVF_EN.
//     When it is defined, the signed-overflow port ovf and its logic are built.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (IDLE)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry in, add mode only
//   sub        in   1      1: a - b, 0: a + b + cin
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  result, modulo 2^WIDTH; holds until next accept
//   cout       out  1      final carry; in sub mode 1 means no borrow
//   ovf        out  1      signed overflow (ADDER_OVF_EN only)
module multicycle_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADDER_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int SW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;      // b already inverted for subtract
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic             cout_r;
   logic [SW-1:0]    slice;
   logic [CHUNK:0]   slice_res;
   logic             last_slice;
   logic             accept;

   assign accept     = (state == IDLE) && in_valid;
   assign last_slice = (slice == SW'(NCHUNK - 1));

   // One CHUNK+1 bit add per cycle; the top bit is the carry into the next slice.
   assign slice_res = {1'b0, a_r[slice*CHUNK +: CHUNK]}
                    + {1'b0, b_r[slice*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry_r};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)   state_nxt = RUN;
         RUN:     if (last_slice) state_nxt = DONE;
         DONE:    if (out_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Operand latches and slice datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         slice   <= '0;
      end else if (accept) begin
         a_r     <= a;
         // Subtraction is a + ~b + 1, so the +1 goes in as the initial carry.
         b_r     <= sub ? ~b : b;
         carry_r <= sub ? 1'b1 : cin;
         sum_r   <= '0;
         slice   <= '0;
      end else if (state == RUN) begin
         sum_r[slice*CHUNK +: CHUNK] <= slice_res[CHUNK-1:0];
         carry_r                     <= slice_res[CHUNK];
         slice                       <= slice + SW'(1);
         if (last_slice) cout_r <= slice_res[CHUNK];
      end
   end

`ifdef ADDER_OVF_EN
   logic ovf_r;

   // Operands with the same sign but a result of the other sign mean overflow.
   // The sign of the result is the top bit of the last slice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (state == RUN && last_slice) begin
         ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                  (slice_res[CHUNK-1] != a_r[WIDTH-1]);
      end
   end

   assign ovf = ovf_r;
`endif

   assign sum  = sum_r;
   assign cout = cout_r;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder. It drives two instances from the same inputs:
// one with CHUNK=4 (four slices) and one with CHUNK=16 (one slice). A plain
// arithmetic reference model supplies every expected value.
module tb_multicycle_adder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, out_ready, cin, sub;
   logic [W-1:0] a, b;

   logic         in_ready4, out_valid4, cout4;
   logic [W-1:0] sum4;
   logic         in_ready16, out_valid16, cout16;
   logic [W-1:0] sum16;
`ifdef ADDER_OVF_EN
   logic         ovf4, ovf16;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multicycle_adder #(.WIDTH(W), .CHUNK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4), .cout(cout4)
`ifdef ADDER_OVF_EN
      ,.ovf(ovf4)
`endif
   );

   multicycle_adder #(.WIDTH(W), .CHUNK(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16), .cout(cout16)
`ifdef ADDER_OVF_EN
      ,.ovf(ovf16)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: integer arithmetic on the operand values.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s,
                                 output logic [W-1:0] r, output logic co, output logic ov);
      int ux, uy, sx, sy, full, sres;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (!s) begin
         full = ux + uy + int'(ci);
         sres = sx + sy + int'(ci);
         co   = (full >= 65536);
      end else begin
         full = ux - uy;
         sres = sx - sy;
         co   = (ux >= uy);
      end
      r  = W'(full & 32'hFFFF);
      ov = (sres > 32767) || (sres < -32768);
   endfunction

   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic ci, input logic s, input int hold);
      logic [W-1:0] es;
      logic         ec, eo;
      int           lat4, lat16;
      model(xa, xb, ci, s, es, ec, eo);
      chk("in_ready4_idle", 32'(in_ready4), 32'd1);
      chk("in_ready16_idle", 32'(in_ready16), 32'd1);
      a = xa; b = xb; cin = ci; sub = s;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Operands may change after the accept edge without affecting the result.
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat4 = -1; lat16 = -1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (out_valid4 && lat4 < 0) lat4 = c;
         if (out_valid16 && lat16 < 0) lat16 = c;
         if (lat4 > 0 && lat16 > 0) break;
      end
      chk("latency4", 32'(lat4), 32'd4);
      chk("latency16", 32'(lat16), 32'd1);
      chk("sum4", 32'(sum4), 32'(es));
      chk("cout4", 32'(cout4), 32'(ec));
      chk("sum16", 32'(sum16), 32'(es));
      chk("cout16", 32'(cout16), 32'(ec));
`ifdef ADDER_OVF_EN
      chk("ovf4", 32'(ovf4), 32'(eo));
      chk("ovf16", 32'(ovf16), 32'(eo));
`endif
      // Backpressure: the result holds and new operands are refused.
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom);
         a = W'($urandom); b = W'($urandom);
         @(posedge clk); #1;
         chk("hold_valid4", 32'(out_valid4), 32'd1);
         chk("hold_ready4", 32'(in_ready4), 32'd0);
         chk("hold_sum4", 32'(sum4), 32'(es));
         chk("hold_cout4", 32'(cout4), 32'(ec));
         chk("hold_sum16", 32'(sum16), 32'(es));
         chk("hold_ready16", 32'(in_ready16), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("drain_valid4", 32'(out_valid4), 32'd0);
      chk("drain_ready4", 32'(in_ready4), 32'd1);
      chk("idle_sum4", 32'(sum4), 32'(es));
      chk("drain_valid16", 32'(out_valid16), 32'd0);
      chk("idle_sum16", 32'(sum16), 32'(es));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      cin = 1'b0; sub = 1'b0; a = '0; b = '0;
      #12;
      chk("rst_sum4", 32'(sum4), 32'd0);
      chk("rst_cout4", 32'(cout4), 32'd0);
      chk("rst_valid4", 32'(out_valid4), 32'd0);
      chk("rst_ready4", 32'(in_ready4), 32'd1);
      chk("rst_valid16", 32'(out_valid16), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1);
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
      run_op(16'h0000, 16'h8000, 1'b0, 1'b1, 0);
      run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 5);

      // Reset after two slices of a four-slice operation.
      a = 16'h1234; b = 16'h0FFF; cin = 1'b1; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid4", 32'(out_valid4), 32'd0);
      chk("midrst_sum4", 32'(sum4), 32'd0);
      chk("midrst_cout4", 32'(cout4), 32'd0);
      chk("midrst_ready4", 32'(in_ready4), 32'd1);
      chk("midrst_valid16", 32'(out_valid16), 32'd0);
      chk("midrst_sum16", 32'(sum16), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0);

      for (int i = 0; i < 25; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
